// File: rtl/lza_norm_shift_stage.sv
// lza_norm_shift_stage: two-step normalization shifter that sits behind detection_tree.
// Step 1 applies the anticipated leading-zero count and step 2 applies the one-bit
// nshift_correct fix-up. Valid/ready on both sides, one item per cycle, two register stages.
// Optional build macro LZA_NORM_ERRCHK_EN adds out_norm_err, a registered flag that the
// applied shift failed to bring a non-zero magnitude's MSB to the top bit.
module lza_norm_shift_stage #(
   parameter  int DATA_WIDTH  = 8,
   localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic [SHIFT_WIDTH-1:0] in_lza_cnt,
   input  logic                   in_nshift_corr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic [SHIFT_WIDTH:0]   out_shift,
   output logic                   out_zero
`ifdef LZA_NORM_ERRCHK_EN
   ,
   output logic                   out_norm_err
`endif
);

   logic                   s1Valid_q, s1Valid_d;
   logic [DATA_WIDTH-1:0]  s1Data_q, s1Data_d;
   logic [SHIFT_WIDTH-1:0] s1Cnt_q, s1Cnt_d;
   logic                   s1Corr_q, s1Corr_d;
   logic                   s1Zero_q, s1Zero_d;

   logic                   outValid_q, outValid_d;
   logic [DATA_WIDTH-1:0]  outData_q, outData_d;
   logic [SHIFT_WIDTH:0]   outShift_q, outShift_d;
   logic                   outZero_q, outZero_d;
`ifdef LZA_NORM_ERRCHK_EN
   logic                   outErr_q, outErr_d;
`endif

   logic                   s2Ready;
   logic                   s1Advance;
   logic                   inFire;
   logic [DATA_WIDTH-1:0]  fineData;

   // Handshake: readiness is derived only from the register valids and out_ready,
   // so there is never a path from in_valid to out_valid.
   always_comb begin
      s2Ready   = ~outValid_q | out_ready;
      in_ready  = ~s1Valid_q | s2Ready;
      inFire    = in_valid & in_ready;
      s1Advance = s1Valid_q & s2Ready;
   end

   // Stage 1 next state: coarse shift by the anticipated count; refills in the same cycle it drains.
   always_comb begin
      s1Valid_d = s1Valid_q;
      s1Data_d  = s1Data_q;
      s1Cnt_d   = s1Cnt_q;
      s1Corr_d  = s1Corr_q;
      s1Zero_d  = s1Zero_q;
      if (s1Advance) begin
         s1Valid_d = 1'b0;
      end
      if (inFire) begin
         s1Valid_d = 1'b1;
         s1Data_d  = in_data << in_lza_cnt;
         s1Cnt_d   = in_lza_cnt;
         s1Corr_d  = in_nshift_corr;
         s1Zero_d  = (in_data == '0);
      end
   end

   // Fine shift: one extra position when detection_tree reports the anticipation was one short.
   always_comb begin
      fineData = s1Data_q;
      if (s1Corr_q) begin
         fineData = {s1Data_q[DATA_WIDTH-2:0], 1'b0};
      end
   end

   // Stage 2 next state: holds steady while stalled, loads whenever stage 1 advances.
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outShift_d = outShift_q;
      outZero_d  = outZero_q;
`ifdef LZA_NORM_ERRCHK_EN
      outErr_d   = outErr_q;
`endif
      if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end
      if (s1Advance) begin
         outValid_d = 1'b1;
         outData_d  = fineData;
         outShift_d = {1'b0, s1Cnt_q} + {{SHIFT_WIDTH{1'b0}}, s1Corr_q};
         outZero_d  = s1Zero_q;
`ifdef LZA_NORM_ERRCHK_EN
         outErr_d   = ~s1Zero_q & ~fineData[DATA_WIDTH-1];
`endif
      end
   end

   // Pipeline registers; reset discards any in-flight items.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid_q  <= 1'b0;
         s1Data_q   <= '0;
         s1Cnt_q    <= '0;
         s1Corr_q   <= 1'b0;
         s1Zero_q   <= 1'b0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outShift_q <= '0;
         outZero_q  <= 1'b0;
`ifdef LZA_NORM_ERRCHK_EN
         outErr_q   <= 1'b0;
`endif
      end else begin
         s1Valid_q  <= s1Valid_d;
         s1Data_q   <= s1Data_d;
         s1Cnt_q    <= s1Cnt_d;
         s1Corr_q   <= s1Corr_d;
         s1Zero_q   <= s1Zero_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outShift_q <= outShift_d;
         outZero_q  <= outZero_d;
`ifdef LZA_NORM_ERRCHK_EN
         outErr_q   <= outErr_d;
`endif
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_shift = outShift_q;
   assign out_zero  = outZero_q;
`ifdef LZA_NORM_ERRCHK_EN
   assign out_norm_err = outErr_q;
`endif

endmodule

// File: tb/tb_lza_norm_shift_stage.sv
// tb_lza_norm_shift_stage: self-checking bench for lza_norm_shift_stage (DATA_WIDTH=8).
// Expected results come from a plain-arithmetic model of the normalization rules and a
// queue of items in flight. Define LZA_NORM_ERRCHK_EN to also check out_norm_err.
module tb_lza_norm_shift_stage;

   localparam int DW = 8;

   typedef struct {
      logic [7:0] data;
      logic [2:0] cnt;
      logic       corr;
   } item_t;

   typedef struct {
      logic [7:0] data;
      logic [3:0] shift;
      logic       zero;
      logic       err;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [2:0] in_lza_cnt = '0;
   logic       in_nshift_corr = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [3:0] out_shift;
   logic       out_zero;
`ifdef LZA_NORM_ERRCHK_EN
   logic       out_norm_err;
`endif

   int   nCompared = 0;
   int   nMismatched = 0;
   res_t expQ[$];

   lza_norm_shift_stage #(.DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_lza_cnt     (in_lza_cnt),
      .in_nshift_corr (in_nshift_corr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_shift      (out_shift),
      .out_zero       (out_zero)
`ifdef LZA_NORM_ERRCHK_EN
      ,
      .out_norm_err   (out_norm_err)
`endif
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Behavioural model: total shift, multiply by 2^total truncated to 8 bits, zero and error flags.
   function automatic res_t modelItem(input item_t it);
      int   total;
      int   shifted;
      res_t r;
      total = int'(it.cnt) + int'(it.corr);
      if (total >= DW) shifted = 0;
      else             shifted = (int'(it.data) * (1 << total)) % 256;
      r.data  = 8'(shifted);
      r.shift = 4'(total);
      r.zero  = (it.data == 8'h00);
      r.err   = !r.zero && (shifted < 128);
      return r;
   endfunction

   function automatic item_t randItem();
      item_t it;
      it.data = 8'($urandom);
      if ($urandom_range(0, 7) == 0) it.data = 8'h00;
      it.cnt  = 3'($urandom_range(0, 7));
      it.corr = 1'($urandom_range(0, 1));
      return it;
   endfunction

   // Drive one cycle of inputs at the falling edge, then sample which transfers the next rising edge will make.
   task automatic applyStimulus(input logic iv, input item_t it, input logic ordy,
                                output logic inF, output logic outF);
      @(negedge clk);
      in_valid       = iv;
      in_data        = it.data;
      in_lza_cnt     = it.cnt;
      in_nshift_corr = it.corr;
      out_ready      = ordy;
      #1;
      inF  = in_valid & in_ready;
      outF = out_valid & out_ready;
   endtask

   // Outputs must be all zero while reset is held.
   task automatic test_reset();
      #2;
      nCompared++;
      if (out_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid);
      end
      nCompared++;
      if ({out_data, out_shift, out_zero} !== 13'h0) begin
         nMismatched++;
         $display("[TB] FAIL reset_outputs got data=%h shift=%0d zero=%b exp all 0", out_data, out_shift, out_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One item through an idle pipe with out_ready high: output appears after the second rising edge.
   task automatic test_directed(input string name, input item_t it, input res_t e);
      logic  inF, outF;
      item_t idle;
      idle = '{8'h00, 3'd0, 1'b0};
      applyStimulus(1'b1, it, 1'b1, inF, outF);
      nCompared++;
      if (inF !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL %s_accept got %b exp 1", name, inF);
      end
      applyStimulus(1'b0, idle, 1'b1, inF, outF);
      nCompared++;
      if (out_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL %s_early_valid got %b exp 0", name, out_valid);
      end
      applyStimulus(1'b0, idle, 1'b1, inF, outF);
      nCompared++;
      if (out_valid !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL %s_valid got %b exp 1", name, out_valid);
      end
      nCompared++;
      if ({out_data, out_shift, out_zero} !== {e.data, e.shift, e.zero}) begin
         nMismatched++;
         $display("[TB] FAIL %s_result got data=%h shift=%0d zero=%b exp data=%h shift=%0d zero=%b",
                  name, out_data, out_shift, out_zero, e.data, e.shift, e.zero);
      end
`ifdef LZA_NORM_ERRCHK_EN
      nCompared++;
      if (out_norm_err !== e.err) begin
         nMismatched++;
         $display("[TB] FAIL %s_norm_err got %b exp %b", name, out_norm_err, e.err);
      end
`endif
   endtask

   // Continuous valid and ready: one accept every cycle and one output every cycle after the fill.
   task automatic test_back_to_back();
      logic  inF, outF;
      item_t it;
      res_t  e;
      for (int k = 0; k < 12; k++) begin
         it = randItem();
         applyStimulus(k < 10, it, 1'b1, inF, outF);
         if (k < 10) begin
            nCompared++;
            if (inF !== 1'b1) begin
               nMismatched++;
               $display("[TB] FAIL b2b_accept cycle %0d got %b exp 1", k, inF);
            end
         end
         nCompared++;
         if (outF !== (k >= 2)) begin
            nMismatched++;
            $display("[TB] FAIL b2b_output_bubble cycle %0d got %b exp %b", k, outF, (k >= 2));
         end
         if (inF) expQ.push_back(modelItem(it));
         if (outF && expQ.size() > 0) begin
            e = expQ.pop_front();
            nCompared++;
            if ({out_data, out_shift, out_zero} !== {e.data, e.shift, e.zero}) begin
               nMismatched++;
               $display("[TB] FAIL b2b_result got data=%h shift=%0d zero=%b exp data=%h shift=%0d zero=%b",
                        out_data, out_shift, out_zero, e.data, e.shift, e.zero);
            end
         end
      end
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL b2b_leftover got %0d items exp 0", expQ.size());
      end
      expQ.delete();
   endtask

   // Five items against a downstream stall of four cycles, then drain in order.
   task automatic test_backpressure();
      logic  inF, outF;
      item_t items[5];
      res_t  e;
      int    idx;
      int    cyc;
      logic [12:0] snap;
      foreach (items[i]) items[i] = randItem();
      idx = 0;
      snap = '0;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b1, items[idx], 1'b0, inF, outF);
         nCompared++;
         if (inF !== (c < 2)) begin
            nMismatched++;
            $display("[TB] FAIL bp_in_ready cycle %0d got %b exp %b", c, inF, (c < 2));
         end
         if (inF) begin
            expQ.push_back(modelItem(items[idx]));
            idx++;
         end
         if (c == 2) begin
            snap = {out_data, out_shift, out_zero};
            nCompared++;
            if (out_valid !== 1'b1 || snap !== {expQ[0].data, expQ[0].shift, expQ[0].zero}) begin
               nMismatched++;
               $display("[TB] FAIL bp_stalled_head got valid=%b data=%h shift=%0d exp valid=1 data=%h shift=%0d",
                        out_valid, out_data, out_shift, expQ[0].data, expQ[0].shift);
            end
         end
         if (c == 3) begin
            nCompared++;
            if (out_valid !== 1'b1 || {out_data, out_shift, out_zero} !== snap) begin
               nMismatched++;
               $display("[TB] FAIL bp_stable got valid=%b outs=%h exp valid=1 outs=%h",
                        out_valid, {out_data, out_shift, out_zero}, snap);
            end
         end
      end
      cyc = 0;
      while ((idx < 5 || expQ.size() > 0) && cyc < 30) begin
         applyStimulus(idx < 5, items[(idx < 5) ? idx : 4], 1'b1, inF, outF);
         if (outF) begin
            nCompared++;
            if (expQ.size() == 0) begin
               nMismatched++;
               $display("[TB] FAIL bp_extra_output got data=%h exp none", out_data);
            end else begin
               e = expQ.pop_front();
               if ({out_data, out_shift, out_zero} !== {e.data, e.shift, e.zero}) begin
                  nMismatched++;
                  $display("[TB] FAIL bp_order got data=%h shift=%0d zero=%b exp data=%h shift=%0d zero=%b",
                           out_data, out_shift, out_zero, e.data, e.shift, e.zero);
               end
            end
         end
         if (inF && idx < 5) begin
            expQ.push_back(modelItem(items[idx]));
            idx++;
         end
         cyc++;
      end
      nCompared++;
      if (idx != 5 || expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL bp_drain_timeout got accepted=%0d pending=%0d exp 5 and 0", idx, expQ.size());
      end
      expQ.delete();
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, items[0], 1'b1, inF, outF);
         nCompared++;
         if (outF !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL bp_duplicate got out_valid=%b exp 0", out_valid);
         end
      end
   endtask

   // Random valid/ready traffic checked in order against the model queue.
   task automatic test_random();
      logic  inF, outF;
      item_t it;
      res_t  e;
      int    cyc;
      for (int k = 0; k < 400; k++) begin
         it = randItem();
         applyStimulus($urandom_range(0, 3) != 0, it, $urandom_range(0, 2) != 0, inF, outF);
         if (outF) begin
            nCompared++;
            if (expQ.size() == 0) begin
               nMismatched++;
               $display("[TB] FAIL rand_extra_output got data=%h exp none", out_data);
            end else begin
               e = expQ.pop_front();
               if ({out_data, out_shift, out_zero} !== {e.data, e.shift, e.zero}) begin
                  nMismatched++;
                  $display("[TB] FAIL rand_result got data=%h shift=%0d zero=%b exp data=%h shift=%0d zero=%b",
                           out_data, out_shift, out_zero, e.data, e.shift, e.zero);
               end
`ifdef LZA_NORM_ERRCHK_EN
               nCompared++;
               if (out_norm_err !== e.err) begin
                  nMismatched++;
                  $display("[TB] FAIL rand_norm_err got %b exp %b", out_norm_err, e.err);
               end
`endif
            end
         end
         if (inF) expQ.push_back(modelItem(it));
      end
      cyc = 0;
      while (expQ.size() > 0 && cyc < 20) begin
         applyStimulus(1'b0, it, 1'b1, inF, outF);
         if (outF) begin
            e = expQ.pop_front();
            nCompared++;
            if ({out_data, out_shift, out_zero} !== {e.data, e.shift, e.zero}) begin
               nMismatched++;
               $display("[TB] FAIL rand_drain got data=%h shift=%0d exp data=%h shift=%0d",
                        out_data, out_shift, e.data, e.shift);
            end
         end
         cyc++;
      end
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("[TB] FAIL rand_drain_timeout got %0d pending exp 0", expQ.size());
      end
      expQ.delete();
   endtask

   // Asynchronous reset with both stages occupied: outputs clear at once and nothing stale emerges.
   task automatic test_reset_midflight();
      logic  inF, outF;
      item_t it;
      it = '{8'h5A, 3'd1, 1'b0};
      applyStimulus(1'b1, it, 1'b0, inF, outF);
      it = '{8'h33, 3'd2, 1'b1};
      applyStimulus(1'b1, it, 1'b0, inF, outF);
      applyStimulus(1'b0, it, 1'b0, inF, outF);
      nCompared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_full got valid=%b in_ready=%b exp 1 and 0", out_valid, in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_shift !== 4'd0) begin
         nMismatched++;
         $display("[TB] FAIL rstmid_clear got valid=%b data=%h shift=%0d exp 0 0 0", out_valid, out_data, out_shift);
      end
      @(negedge clk);
      rst_n = 1'b1;
      expQ.delete();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, it, 1'b1, inF, outF);
         if (c == 0) begin
            nCompared++;
            if (in_ready !== 1'b1) begin
               nMismatched++;
               $display("[TB] FAIL rstmid_in_ready got %b exp 1", in_ready);
            end
         end
         nCompared++;
         if (outF !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_stale cycle %0d got data=%h exp no output", c, out_data);
         end
      end
   endtask

   // Sequence of scenarios followed by the one summary line.
   initial begin
      test_reset();
      test_directed("corrected", '{8'h16, 3'd2, 1'b1}, '{8'hB0, 4'd3, 1'b0, 1'b0});
      test_directed("exact",     '{8'h16, 3'd3, 1'b0}, '{8'hB0, 4'd3, 1'b0, 1'b0});
      test_directed("zero",      '{8'h00, 3'd7, 1'b1}, '{8'h00, 4'd8, 1'b1, 1'b0});
      test_directed("under1",    '{8'h16, 3'd1, 1'b0}, '{8'h2C, 4'd1, 1'b0, 1'b1});
      test_directed("under2",    '{8'h16, 3'd2, 1'b0}, '{8'h58, 4'd2, 1'b0, 1'b1});
      test_directed("overshift", '{8'h81, 3'd7, 1'b1}, '{8'h00, 4'd8, 1'b0, 1'b1});
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout got no finish exp finish before limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
